// File: rtl/jk_reg_bank_if.sv
// jk_reg_bank_if: control, data and status bundle for jk_reg_bank
interface jk_reg_bank_if #(parameter int WIDTH = 4);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             tc;
  logic             chg;
  modport master (output en, mode, j, k, d, ser_in, input q, qb, tc, chg);
  modport slave (input en, mode, j, k, d, ser_in, output q, qb, tc, chg);
endinterface

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH-cell JK/load/count/shift register bank with tc and chg flags; count-up mode built only when JK_REG_BANK_COUNT_EN is defined
module jk_reg_bank #(
  parameter int             WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input logic          clk,
  input logic          rst,
  jk_reg_bank_if.slave bus
);
  logic [WIDTH-1:0] q_q, q_d, qb_q, qb_d, nx, jk, shl, cnt;
  logic             tc_q, tc_d, chg_q, chg_d, wrap;
  always_comb begin
    jk    = (bus.j & ~q_q) | (~bus.k & q_q);
    shl   = (q_q << 1) | WIDTH'(bus.ser_in);
`ifdef JK_REG_BANK_COUNT_EN
    cnt   = q_q + WIDTH'(1);
    wrap  = &q_q;
`else
    cnt   = q_q;
    wrap  = 1'b0;
`endif
    nx    = bus.mode == 2'b00 ? jk : bus.mode == 2'b01 ? bus.d : bus.mode == 2'b10 ? cnt : shl;
    q_d   = rst ? RST_VAL : bus.en ? nx : q_q;
    qb_d  = ~q_d;
    tc_d  = !rst && bus.en && bus.mode == 2'b10 && wrap;
    chg_d = !rst && bus.en && nx != q_q;
  end
  always_ff @(posedge clk) begin
    q_q   <= q_d;
    qb_q  <= qb_d;
    tc_q  <= tc_d;
    chg_q <= chg_d;
  end
  assign bus.q   = q_q;
  assign bus.qb  = qb_q;
  assign bus.tc  = tc_q;
  assign bus.chg = chg_q;
endmodule

// File: tb/tb_jk_reg_bank.sv
// tb_jk_reg_bank: directed scoreboard bench for jk_reg_bank at WIDTH=4
module tb_jk_reg_bank;
  typedef struct {
    int         id;
    logic [3:0] q;
    logic       tc;
    logic       chg;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   step_id = 0;
  exp_t exp_q[$];
  jk_reg_bank_if #(.WIDTH(4)) bus ();
  jk_reg_bank #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests += 4;
      if (bus.q !== e.q) begin
        n_fail++;
        $display("FAIL step%0d q: got %b want %b", e.id, bus.q, e.q);
      end
      if (bus.qb !== ~e.q) begin
        n_fail++;
        $display("FAIL step%0d qb: got %b want %b", e.id, bus.qb, ~e.q);
      end
      if (bus.tc !== e.tc) begin
        n_fail++;
        $display("FAIL step%0d tc: got %b want %b", e.id, bus.tc, e.tc);
      end
      if (bus.chg !== e.chg) begin
        n_fail++;
        $display("FAIL step%0d chg: got %b want %b", e.id, bus.chg, e.chg);
      end
    end
  end
  task automatic step(input logic r, input logic en, input logic [1:0] m,
                      input logic [3:0] jj, input logic [3:0] kk, input logic [3:0] dd,
                      input logic s, input logic [3:0] eq, input logic etc, input logic echg);
    exp_t e;
    @(negedge clk);
    rst        = r;
    bus.en     = en;
    bus.mode   = m;
    bus.j      = jj;
    bus.k      = kk;
    bus.d      = dd;
    bus.ser_in = s;
    e.id  = step_id;
    e.q   = eq;
    e.tc  = etc;
    e.chg = echg;
    exp_q.push_back(e);
    step_id++;
  endtask
  initial begin
    bus.en = 1'b0;
    bus.mode = 2'b00;
    bus.j = 4'h0;
    bus.k = 4'h0;
    bus.d = 4'h0;
    bus.ser_in = 1'b0;
    step(1, 1, 2'b01, 4'h0, 4'h0, 4'hF, 1, 4'b0000, 0, 0);
    step(1, 0, 2'b10, 4'hF, 4'hF, 4'hF, 1, 4'b0000, 0, 0);
    step(0, 0, 2'b00, 4'hA, 4'h6, 4'h0, 0, 4'b0000, 0, 0);
    step(0, 0, 2'b01, 4'h0, 4'h0, 4'hF, 0, 4'b0000, 0, 0);
    step(0, 0, 2'b11, 4'h0, 4'h0, 4'h0, 1, 4'b0000, 0, 0);
    step(0, 1, 2'b00, 4'b1010, 4'b0110, 4'h0, 0, 4'b1010, 0, 1);
    step(0, 1, 2'b00, 4'b1010, 4'b0110, 4'h0, 0, 4'b1000, 0, 1);
    step(0, 1, 2'b00, 4'b0000, 4'b0000, 4'hF, 1, 4'b1000, 0, 0);
    step(0, 1, 2'b00, 4'b0111, 4'b1000, 4'h0, 0, 4'b0111, 0, 1);
    step(0, 1, 2'b01, 4'h0, 4'h0, 4'b1101, 0, 4'b1101, 0, 1);
`ifdef JK_REG_BANK_COUNT_EN
    step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b1110, 0, 1);
    step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b1111, 0, 1);
    step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b0000, 1, 1);
    step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b0001, 0, 1);
`else
    step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b1101, 0, 0);
    step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b1101, 0, 0);
    step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b1101, 0, 0);
    step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b1101, 0, 0);
`endif
    step(0, 1, 2'b01, 4'h0, 4'h0, 4'b0000, 0, 4'b0000, 0, 1);
    step(0, 1, 2'b11, 4'h0, 4'h0, 4'h0, 1, 4'b0001, 0, 1);
    step(0, 1, 2'b11, 4'h0, 4'h0, 4'h0, 0, 4'b0010, 0, 1);
    step(0, 1, 2'b11, 4'h0, 4'h0, 4'h0, 1, 4'b0101, 0, 1);
    step(0, 1, 2'b11, 4'h0, 4'h0, 4'h0, 1, 4'b1011, 0, 1);
    step(0, 1, 2'b11, 4'h0, 4'h0, 4'h0, 0, 4'b0110, 0, 1);
    step(0, 0, 2'b11, 4'h0, 4'h0, 4'h0, 1, 4'b0110, 0, 0);
    step(0, 1, 2'b01, 4'h0, 4'h0, 4'b0110, 0, 4'b0110, 0, 0);
    step(1, 1, 2'b10, 4'h0, 4'h0, 4'hF, 1, 4'b0000, 0, 0);
`ifdef JK_REG_BANK_COUNT_EN
    step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b0001, 0, 1);
`else
    step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b0000, 0, 0);
`endif
    step(0, 1, 2'b01, 4'h0, 4'h0, 4'b0101, 0, 4'b0101, 0, 1);
`ifdef JK_REG_BANK_COUNT_EN
    step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b0110, 0, 1);
    step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b0111, 0, 1);
    step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b1000, 0, 1);
    step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b1001, 0, 1);
`else
    step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b0101, 0, 0);
    step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b0101, 0, 0);
    step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b0101, 0, 0);
    step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b0101, 0, 0);
`endif
    step(0, 1, 2'b01, 4'h0, 4'h0, 4'b1111, 0, 4'b1111, 0, 1);
`ifdef JK_REG_BANK_COUNT_EN
    step(0, 0, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b1111, 0, 0);
    step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b0000, 1, 1);
    step(0, 0, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b0000, 0, 0);
`else
    step(0, 0, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b1111, 0, 0);
    step(0, 1, 2'b10, 4'h0, 4'h0, 4'h0, 0, 4'b1111, 0, 0);
    step(0, 1, 2'b00, 4'b1111, 4'b1111, 4'h0, 0, 4'b0000, 0, 1);
`endif
    step(0, 1, 2'b00, 4'b0101, 4'b0101, 4'h0, 0, 4'b0101, 0, 1);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/jk_reg_bank.md
JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
- REQ-001: Parameter WIDTH, default 4, meaning the number of JK cells in the bank (legal range 1..32).
- REQ-002: Parameter RST_VAL, default {WIDTH{1'b0}}, meaning the value loaded into q on reset.
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: rst  input  1  reset, synchronous, active-high.
- REQ-005: en  input  1  clock enable; 0 = hold all state.
- REQ-006: mode  input  2  operation select: 00 JK, 01 parallel load, 10 count up, 11 shift left.
- REQ-007: j  input  WIDTH  per-bit J inputs, used in mode 00.
- REQ-008: k  input  WIDTH  per-bit K inputs, used in mode 00.
- REQ-009: d  input  WIDTH  parallel load data, used in mode 01.
- REQ-010: ser_in  input  1  serial input shifted into bit 0 in mode 11.
- REQ-011: q  output  WIDTH  registered bank state.
- REQ-012: qb  output  WIDTH  registered complement of q.
- REQ-013: tc  output  1  registered terminal-count pulse.
- REQ-014: chg  output  1  registered flag: q changed on the last active edge.

Function
- REQ-015: qb SHALL equal ~q in every cycle, updated on the same edge as q with zero lag.
- REQ-016: With en=0 and rst=0, q SHALL hold; tc and chg SHALL be 0 after the edge.
- REQ-017: In mode 00, each bit i SHALL update per its {j[i],k[i]} pair: 00 hold, 01 clear to 0, 10 set to 1, 11 toggle.
- REQ-018: In mode 01, q SHALL load d on the edge.
- REQ-019: In mode 10, q SHALL increment by 1 modulo 2^WIDTH per edge; all-ones SHALL wrap to zero.
- REQ-020: tc SHALL be 1 for exactly the one cycle following an edge on which q went from all-ones to zero in mode 10; tc SHALL be 0 otherwise.
- REQ-021: In mode 11, q SHALL become {q[WIDTH-2:0], ser_in}; for WIDTH=1, q SHALL become ser_in.
- REQ-022: chg SHALL be 1 for the cycle after any edge where the new q differs from the old q; chg SHALL be 0 otherwise, including in mode 00 with all pairs at 00.
- REQ-023: A change of mode SHALL take effect on the first edge at which the new mode is sampled, with no idle cycle.
- REQ-024: All inputs SHALL be sampled only at the rising edge of clk; all outputs SHALL be registered.

Reset
- REQ-025: On an edge with rst=1, the block SHALL set q=RST_VAL, qb=~RST_VAL, tc=0 and chg=0.
- REQ-026: rst SHALL dominate en, mode and all data inputs.
- REQ-027: Reset asserted mid-count or mid-shift SHALL abort the operation; on the first edge after rst deasserts, the block SHALL resume from RST_VAL.
- REQ-028: No output SHALL be X after the first rst edge.

Configuration
- REQ-029: Macro JK_REG_BANK_COUNT_EN SHALL control the count-up mode.
- REQ-030: With JK_REG_BANK_COUNT_EN defined, mode 10 SHALL behave per REQ-019 and REQ-020.
- REQ-031: With JK_REG_BANK_COUNT_EN undefined, mode 10 SHALL hold q, tc SHALL be tied to 0, and no incrementer logic SHALL be synthesised.

Verification (WIDTH=4, RST_VAL=0 unless stated)
- REQ-032: rst=1 for 2 edges, then rst=0, en=0 for 3 edges -> q=0000, qb=1111, tc=0, chg=0 throughout.
- REQ-033: en=1, mode=00; drive {j,k} bit-pairs for bits 3..0 = 10,01,11,00 from q=0000 -> q=1010, chg=1; repeat the same pairs -> q=1000, chg=1; all pairs 00 -> q=1000, chg=0.
- REQ-034: mode=01, d=1101, then mode=10 for 3 edges (macro defined) -> q=1101, 1110, 1111, 0000; tc=1 only in the cycle showing 0000, 0 on the next edge.
- REQ-035: mode=11 from q=0000 with ser_in=1,0,1,1 -> q=0001, 0010, 0101, 1011; qb=~q every cycle.
- REQ-036: Counting from q=0110 in mode 10, assert rst on one edge -> q=0000, tc=0, chg=0; deassert rst -> q=0001 on the next edge.
- REQ-037: Build without JK_REG_BANK_COUNT_EN, load 0101, then mode=10 for 4 edges -> q stays 0101, tc=0, chg=0.
